test_port_sniffer: RTL and testbench

TEST_PORT_SNIFFER -- requirements
Module: test_port_sniffer

---
 rtl/test_port_sniffer.sv | 137 +++++++++++++
 tb/tb_test_port_sniffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/test_port_sniffer.sv
// Test-port sniffer: captures byte-swapped writes to TEST_PORT between BEGIN_SYM and END_SYM into a FIFO.
// Optional feature macro SNIFF_TIMESTAMP_EN adds out_stamp (cycles since entering ARMED, per entry).
module test_port_sniffer #(
   parameter logic [29:0] TEST_PORT = 30'h3FF,
   parameter logic [31:0] BEGIN_SYM = 32'h00000168,
   parameter logic [31:0] END_SYM   = 32'hFFFFFD5D,
   parameter int          DEPTH     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] addr,
   input  logic [31:0] data,
   input  logic        wen,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        armed,
   output logic        done,
   output logic        overflow,
   output logic [9:0]  cap_count
`ifdef SNIFF_TIMESTAMP_EN
   ,
   output logic [15:0] out_stamp
`endif
);
   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
   state_t state, state_nxt;

   logic [31:0]   swapped;
   logic          wen_was_low;
   logic          qualify;
   logic          push_req;
   logic          begin_hit;
   logic          push_ok;
   logic          drop;
   logic          pop;
   logic          full;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [31:0]   data_mem [DEPTH];
   logic          last_mem [DEPTH];

   assign swapped = {data[7:0], data[15:8], data[23:16], data[31:24]};
   // wen_was_low clears on reset, so a wen run straddling reset release needs a low edge first.
   assign qualify = wen && wen_was_low && (addr == TEST_PORT);
   assign full    = (count == FULL_CNT);
   assign pop     = out_valid && out_ready;
   assign push_ok = push_req && (!full || pop);
   assign drop    = push_req && full && !pop;

   // NOTE: every signal driven here gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_nxt = state;
      push_req  = 1'b0;
      begin_hit = 1'b0;
      armed     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (qualify && (swapped == BEGIN_SYM)) begin
               begin_hit = 1'b1;
               state_nxt = ARMED;
            end
         end
         ARMED: begin
            armed = 1'b1;
            if (qualify) begin
               push_req = 1'b1;
               if (swapped == END_SYM) state_nxt = DONE;
            end
         end
         DONE:    done = 1'b1;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wen_was_low <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         overflow    <= 1'b0;
         cap_count   <= '0;
      end else begin
         state       <= state_nxt;
         wen_was_low <= !wen;
         if (begin_hit) begin
            cap_count <= '0;
            overflow  <= 1'b0;
         end else begin
            if (push_ok && (cap_count != 10'h3FF)) cap_count <= cap_count + 10'd1;
            if (drop) overflow <= 1'b1;
         end
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
      end
   end

   // NOTE: FIFO storage has no reset; the outputs are gated by out_valid so stale entries never leak.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         data_mem[wr_ptr] <= swapped;
         last_mem[wr_ptr] <= (swapped == END_SYM);
      end
   end

   assign out_valid = (count != '0);
   assign out_data  = out_valid ? data_mem[rd_ptr] : '0;
   assign out_last  = out_valid && last_mem[rd_ptr];

`ifdef SNIFF_TIMESTAMP_EN
   logic [15:0] stamp_cnt;
   logic [15:0] stamp_mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                          stamp_cnt <= '0;
      else if (begin_hit)                               stamp_cnt <= '0;
      else if ((state == ARMED) && (stamp_cnt != 16'hFFFF)) stamp_cnt <= stamp_cnt + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (push_ok) stamp_mem[wr_ptr] <= stamp_cnt;
   end

   assign out_stamp = out_valid ? stamp_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_test_port_sniffer.sv
// Scoreboard bench for test_port_sniffer: driver pushes expected words, a negedge monitor pops and compares.
module tb_test_port_sniffer;
   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] addr;
   logic [31:0] data;
   logic        wen;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        armed;
   logic        done;
   logic        overflow;
   logic [9:0]  cap_count;

   int   pass_cnt  = 0;
   int   total_cnt = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   test_port_sniffer dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .data      (data),
      .wen       (wen),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .armed     (armed),
      .done      (done),
      .overflow  (overflow),
      .cap_count (cap_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
      else pass_cnt++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [29:0] a, input logic [31:0] d, input int cycles);
      addr = a;
      data = d;
      wen  = 1'b1;
      repeat (cycles) tick();
      wen = 1'b0;
      tick();
   endtask

   task automatic push_exp(input logic [31:0] d, input logic l);
      exp_t e;
      e.d = d;
      e.l = l;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while (((exp_q.size() != 0) || out_valid) && (n < 60)) begin
         tick();
         n++;
      end
      check("drain_complete", {31'd0, (exp_q.size() == 0) && !out_valid}, 32'd1);
      out_ready = 1'b0;
   endtask

   task automatic reset_and_arm();
      rst = 1'b1;
      #1;
      exp_q.delete();
      tick();
      rst = 1'b0;
      tick();
      wr(30'h3FF, 32'h68010000, 1);
      check("rearm_armed", armed, 1);
   endtask

   // Monitor: a handshake seen at the negedge completes on the following rising edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL extra_word: got %h, no word expected", out_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_data", out_data, e.d);
            check("sb_last", out_last, e.l);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; wen = 1'b0; out_ready = 1'b0; addr = '0; data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data, 0);
      check("rst_out_last",  out_last, 0);
      check("rst_armed",     armed, 0);
      check("rst_done",      done, 0);
      check("rst_overflow",  overflow, 0);
      check("rst_cap_count", cap_count, 0);

      // BEGIN write whose wen run straddles reset release must not arm
      addr = 30'h3FF; data = 32'h68010000; wen = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("straddle_armed_hi", armed, 0);
      wen = 1'b0;
      tick();
      check("straddle_armed_lo", armed, 0);

      // IDLE ignores non-BEGIN data and other addresses
      wr(30'h3FF, 32'h05000000, 1);
      wr(30'h3FE, 32'h68010000, 1);
      check("idle_ignore_armed", armed, 0);
      check("idle_ignore_valid", out_valid, 0);

      // Arm: BEGIN is not pushed
      addr = 30'h3FF; data = 32'h68010000; wen = 1'b1;
      tick();
      check("arm_armed", armed, 1);
      check("arm_valid", out_valid, 0);
      check("arm_cap",   cap_count, 0);
      wen = 1'b0;
      tick();

      // wen held 4 cycles: one word, 1-cycle latency
      out_ready = 1'b1;
      push_exp(32'd5, 1'b0);
      addr = 30'h3FF; data = 32'h05000000; wen = 1'b1;
      tick();
      check("lat_valid", out_valid, 1);
      check("lat_data",  out_data, 32'd5);
      repeat (3) tick();
      wen = 1'b0;
      tick();
      check("stall_cap",   cap_count, 1);
      check("stall_valid", out_valid, 0);
      wr(30'h3FE, 32'h06000000, 1);
      check("other_addr_cap", cap_count, 1);

      // Mid-stream reset discards queued words
      out_ready = 1'b0;
      push_exp(32'd10, 1'b0); wr(30'h3FF, 32'h0A000000, 1);
      push_exp(32'd11, 1'b0); wr(30'h3FF, 32'h0B000000, 1);
      push_exp(32'd12, 1'b0); wr(30'h3FF, 32'h0C000000, 1);
      check("queued_head", out_data, 32'd10);
      check("queued_cap",  cap_count, 4);
      rst = 1'b1;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_armed", armed, 0);
      check("midrst_cap",   cap_count, 0);
      check("midrst_data",  out_data, 0);
      exp_q.delete();
      tick();
      rst = 1'b0;
      tick();
      wr(30'h3FF, 32'h07000000, 1);
      check("postrst_ignore_valid", out_valid, 0);
      check("postrst_ignore_armed", armed, 0);
      wr(30'h3FF, 32'h68010000, 1);
      check("postrst_rearm", armed, 1);

      // Overflow: 9 writes into 8 entries with no consumer
      for (int i = 1; i <= 9; i++) begin
         logic [7:0] b;
         b = 8'(i);
         if (i <= 8) push_exp(32'(i), 1'b0);
         wr(30'h3FF, {b, 24'h0}, 1);
      end
      check("ovf_flag", overflow, 1);
      check("ovf_cap",  cap_count, 8);
      check("ovf_head", out_data, 32'd1);
      drain();

      // Full FIFO with simultaneous pop and push
      reset_and_arm();
      for (int i = 20; i <= 27; i++) begin
         logic [7:0] b;
         b = 8'(i);
         push_exp(32'(i), 1'b0);
         wr(30'h3FF, {b, 24'h0}, 1);
      end
      check("full_no_ovf", overflow, 0);
      check("full_cap",    cap_count, 8);
      push_exp(32'd28, 1'b0);
      addr = 30'h3FF; data = 32'h1C000000; wen = 1'b1; out_ready = 1'b1;
      tick();
      wen = 1'b0; out_ready = 1'b0;
      tick();
      check("simul_no_ovf", overflow, 0);
      check("simul_cap",    cap_count, 9);
      wr(30'h3FF, 32'h1D000000, 1);
      check("still_full_ovf", overflow, 1);
      check("still_full_cap", cap_count, 9);
      drain();

      // END marker: flagged entry, DONE, later writes ignored
      push_exp(32'hFFFFFD5D, 1'b1);
      wr(30'h3FF, 32'h5DFDFFFF, 1);
      check("end_valid", out_valid, 1);
      check("end_data",  out_data, 32'hFFFFFD5D);
      check("end_last",  out_last, 1);
      check("end_done",  done, 1);
      check("end_armed", armed, 0);
      check("end_cap",   cap_count, 10);
      wr(30'h3FF, 32'h0A000000, 1);
      wr(30'h3FF, 32'h68010000, 1);
      check("done_ignore_cap", cap_count, 10);
      drain();
      check("done_sticky", done, 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
